// File: rtl/record_tx_arbiter.sv
// Round-robin arbiter draining N record FIFOs into one UART serializer.
// Each record is framed as {8'h0A, source index, record} and sent with a one-cycle trigger.
module record_tx_arbiter #(
    parameter int N_SOURCES      = 4,
    parameter int RECORD_WIDTH   = 144,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [N_SOURCES-1:0]              src_empty,
    input  logic [N_SOURCES*RECORD_WIDTH-1:0] src_data,
    output logic [N_SOURCES-1:0]              src_rdnext,
    output logic [RECORD_WIDTH+15:0]          tx_data,
    output logic                              tx_send,
    input  logic                              tx_done,
    output logic                              busy,
    output logic [7:0]                        grant_id,
    output logic [31:0]                       records_sent,
    output logic                              tx_timeout
);

    localparam int IDX_W = $clog2(N_SOURCES);
    localparam int SUM_W = IDX_W + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_SOURCES-1:0] ONE_HOT0   = N_SOURCES'(1);
    localparam logic [7:0]           FRAME_MARK = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic                      do_grant_s;
    logic                      done_ok_s;
    logic                      tmo_hit_s;
    logic [SUM_W-1:0]          cand_s;
    logic                      hit_s;
    logic [IDX_W-1:0]          pick_idx_s;
    logic                      pick_found_s;

    logic [IDX_W-1:0]          last_grant_r;
    logic [N_SOURCES-1:0]      src_rdnext_r;
    logic [RECORD_WIDTH+15:0]  tx_data_r;
    logic                      tx_send_r;
    logic                      busy_r;
    logic [7:0]                grant_id_r;
    logic [31:0]               records_sent_r;
    logic                      tx_timeout_r;
    logic [TMO_W-1:0]          tmo_cnt_r;

    // Round-robin search: first non-empty source after last_grant_r, wrapping
    always_comb begin
        cand_s       = '0;
        hit_s        = 1'b0;
        pick_idx_s   = '0;
        pick_found_s = 1'b0;
        for (int off = 1; off <= N_SOURCES; off++) begin
            cand_s       = SUM_W'(last_grant_r) + SUM_W'(off);
            cand_s       = (cand_s >= SUM_W'(N_SOURCES)) ? cand_s - SUM_W'(N_SOURCES) : cand_s;
            hit_s        = !pick_found_s && !src_empty[cand_s[IDX_W-1:0]];
            pick_idx_s   = hit_s ? cand_s[IDX_W-1:0] : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    // Next-state decode and transfer events
    always_comb begin
        state_s    = state_r;
        do_grant_s = 1'b0;
        done_ok_s  = 1'b0;
        tmo_hit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && pick_found_s) begin
                    state_s    = ST_READ;
                    do_grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ:  state_s = ST_LATCH;
            ST_LATCH: state_s = ST_SEND;
            ST_SEND:  state_s = ST_WAIT;
            ST_WAIT: begin
                // A completion on the last allowed cycle still counts as success
                if (tx_done) begin
                    state_s   = ST_IDLE;
                    done_ok_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s   = ST_IDLE;
                    tmo_hit_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, round-robin pointer and WAIT timer
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r   <= IDX_W'(N_SOURCES - 1);
            src_rdnext_r   <= '0;
            tx_data_r      <= '0;
            tx_send_r      <= 1'b0;
            busy_r         <= 1'b0;
            grant_id_r     <= 8'd0;
            records_sent_r <= 32'd0;
            tx_timeout_r   <= 1'b0;
            tmo_cnt_r      <= '0;
        end else begin
            src_rdnext_r <= do_grant_s ? (ONE_HOT0 << pick_idx_s) : '0;
            tx_send_r    <= (state_r == ST_LATCH);
            busy_r       <= (state_s != ST_IDLE);
            tmo_cnt_r    <= (state_r == ST_WAIT) ? tmo_cnt_r + TMO_W'(1) : '0;
            if (do_grant_s) begin
                last_grant_r <= pick_idx_s;
                grant_id_r   <= 8'(pick_idx_s);
            end
            // FIFO q is valid the cycle after the read strobe
            if (state_r == ST_LATCH) begin
                tx_data_r <= {FRAME_MARK, grant_id_r,
                              src_data[int'(last_grant_r) * RECORD_WIDTH +: RECORD_WIDTH]};
            end
            if (done_ok_s) begin
                records_sent_r <= records_sent_r + 32'd1;
            end
            if (tmo_hit_s) begin
                tx_timeout_r <= 1'b1;
            end
        end
    end

    assign src_rdnext   = src_rdnext_r;
    assign tx_data      = tx_data_r;
    assign tx_send      = tx_send_r;
    assign busy         = busy_r;
    assign grant_id     = grant_id_r;
    assign records_sent = records_sent_r;
    assign tx_timeout   = tx_timeout_r;

endmodule

// File: tb/tb_record_tx_arbiter.sv
// Directed bench for record_tx_arbiter (4 sources, 144-bit records, 16-cycle timeout).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_record_tx_arbiter;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [3:0]   src_empty;
    logic [575:0] src_data;
    logic [3:0]   src_rdnext;
    logic [159:0] tx_data;
    logic         tx_send;
    logic         tx_done;
    logic         busy;
    logic [7:0]   grant_id;
    logic [31:0]  records_sent;
    logic         tx_timeout;

    int vectors     = 0;
    int miscompares = 0;

    record_tx_arbiter #(
        .N_SOURCES      (4),
        .RECORD_WIDTH   (144),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .src_empty    (src_empty),
        .src_data     (src_data),
        .src_rdnext   (src_rdnext),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_done      (tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .records_sent (records_sent),
        .tx_timeout   (tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record held by source s: 18 copies of byte 0x11*(s+1)
    function automatic logic [143:0] rec(input int s);
        return {18{8'(8'h11 * (s + 1))}};
    endfunction

    function automatic logic [159:0] frame(input int s);
        return {8'h0A, 8'(s), rec(s)};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One full transfer; called when the next rising edge sees a grant in IDLE
    task automatic run_record(input int src, input logic [3:0] empty_after, input int exp_rec);
        @(negedge clk);
        chk("rdnext_onehot", src_rdnext, 160'(4'b0001 << src));
        chk("grant_id", grant_id, src);
        chk("busy_grant", busy, 1);
        src_empty = empty_after;
        @(negedge clk);
        chk("rdnext_single", src_rdnext, 0);
        chk("send_early", tx_send, 0);
        @(negedge clk);
        chk("tx_send_pulse", tx_send, 1);
        chk("rdnext_with_send", src_rdnext, 0);
        chk("tx_data", tx_data, frame(src));
        @(negedge clk);
        chk("tx_send_single", tx_send, 0);
        repeat (4) @(negedge clk);
        chk("tx_data_hold", tx_data, frame(src));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("records_sent", records_sent, exp_rec);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        src_empty = 4'hF;
        tx_done   = 1'b0;
        for (int i = 0; i < 4; i++) src_data[i*144 +: 144] = rec(i);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rdnext", src_rdnext, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_records", records_sent, 0);
        chk("rst_timeout", tx_timeout, 0);
        reset = 1'b0;

        // Single source 0 pending
        enable    = 1'b1;
        src_empty = 4'b1110;
        run_record(0, 4'b1111, 1);
        @(negedge clk);
        chk("idle_no_grant", src_rdnext, 0);

        // All sources pending: order 0,1,2,3,0 from reset
        do_reset();
        src_empty = 4'b0000;
        run_record(0, 4'b0000, 1);
        run_record(1, 4'b0000, 2);
        run_record(2, 4'b0000, 3);
        run_record(3, 4'b0000, 4);
        run_record(0, 4'b1111, 5);

        // Only source 2 pending: wrap search regrants it
        src_empty = 4'b1011;
        run_record(2, 4'b1011, 6);
        run_record(2, 4'b1111, 7);

        // Timeout after 16 WAIT cycles with no completion
        src_empty = 4'b0111;
        @(negedge clk);
        chk("tmo_rdnext", src_rdnext, 4'b1000);
        src_empty = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("tmo_send", tx_send, 1);
        repeat (16) @(negedge clk);
        chk("tmo_not_yet", tx_timeout, 0);
        chk("tmo_busy_w16", busy, 1);
        @(negedge clk);
        chk("tmo_flag", tx_timeout, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_count", records_sent, 7);
        src_empty = 4'b1110;
        run_record(0, 4'b1111, 8);
        chk("tmo_sticky", tx_timeout, 1);

        // Enable dropped mid-transfer: record completes, no new grant
        src_empty = 4'b1101;
        @(negedge clk);
        chk("en_rdnext", src_rdnext, 4'b0010);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("en_send", tx_send, 1);
        chk("en_tx_data", tx_data, frame(1));
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("en_records", records_sent, 9);
        chk("en_idle", busy, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("idle_done_ignored", records_sent, 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_off_rdnext", src_rdnext, 0);
            chk("en_off_busy", busy, 0);
        end

        // Reset during WAIT aborts; later tx_done ignored
        enable = 1'b1;
        @(negedge clk);
        chk("rw_rdnext", src_rdnext, 4'b0010);
        src_empty = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("rw_send", tx_send, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_busy", busy, 0);
        chk("rw_records", records_sent, 0);
        chk("rw_timeout", tx_timeout, 0);
        chk("rw_tx_data", tx_data, 0);
        chk("rw_grant_id", grant_id, 0);
        reset   = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("rw_late_done", records_sent, 0);
        chk("rw_late_busy", busy, 0);

        // tx_done on the 16th WAIT cycle wins over the timeout
        src_empty = 4'b1110;
        @(negedge clk);
        chk("edge_rdnext", src_rdnext, 4'b0001);
        src_empty = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("edge_send", tx_send, 1);
        repeat (16) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("edge_no_timeout", tx_timeout, 0);
        chk("edge_records", records_sent, 1);
        chk("edge_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/record_tx_arbiter.md
RECORD_TX_ARBITER -- requirements
Module: record_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SOURCES, default 4, number of record FIFOs sharing one UART serializer (legal 2..16).
REQ-002 SHALL have parameter RECORD_WIDTH, default 144, width of each FIFO q word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, max clk cycles to wait for UART completion.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new grants when high.
REQ-007 SHALL have port src_empty  input  N_SOURCES  per-source FIFO rdempty.
REQ-008 SHALL have port src_data  input  N_SOURCES*RECORD_WIDTH  packed FIFO q; source i at bits [i*RECORD_WIDTH +: RECORD_WIDTH].
REQ-009 SHALL have port src_rdnext  output  N_SOURCES  one-hot FIFO rdreq pulse.
REQ-010 SHALL have port tx_data  output  RECORD_WIDTH+16  registered frame {8'h0A, 8-bit source index, record}.
REQ-011 SHALL have port tx_send  output  1  one-cycle UART trigger pulse.
REQ-012 SHALL have port tx_done  input  1  UART transmission_over.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port grant_id  output  8  index of current/last granted source.
REQ-015 SHALL have port records_sent  output  32  count of completed transmissions.
REQ-016 SHALL have port tx_timeout  output  1  sticky flag, UART completion timeout occurred.

Function
REQ-017 SHALL implement FSM states IDLE, READ, LATCH, SEND, WAIT.
REQ-018 IDLE: if enable=1 and any src_empty bit low, SHALL grant the first non-empty source searching from (last_grant+1) mod N_SOURCES upward with wrap, register grant_id, go to READ; else stay.
REQ-019 Round-robin pointer last_grant SHALL update on each grant; reset value N_SOURCES-1 so source 0 has first priority.
REQ-020 src_empty SHALL be evaluated only in IDLE; changes in other states ignored.
REQ-021 READ: src_rdnext[grant_id]=1 for exactly that cycle, all other bits 0; next state LATCH.
REQ-022 LATCH: tx_data <= {8'h0A, grant_id, src_data slice of grant_id}; next state SEND.
REQ-023 SEND: tx_send=1 for exactly one cycle; next state WAIT; tx_data SHALL stay constant from LATCH until leaving WAIT.
REQ-024 Latency: request seen in IDLE at cycle t -> src_rdnext at t+1, tx_data valid at t+2 end, tx_send at t+3.
REQ-025 WAIT: on tx_done=1 SHALL increment records_sent (wraps 2^32-1 -> 0) and go to IDLE; IDLE may grant again in the following cycle.
REQ-026 tx_done outside WAIT SHALL be ignored (no count, no state change).
REQ-027 WAIT timeout counter SHALL clear on entry; if it reaches TIMEOUT_CYCLES without tx_done, SHALL set tx_timeout, not increment records_sent, return to IDLE.
REQ-028 tx_done in the same cycle the timeout is reached SHALL count as success (no timeout flag).
REQ-029 enable deasserted in READ/LATCH/SEND/WAIT SHALL NOT abort; current record completes, then FSM stays IDLE.
REQ-030 src_rdnext and tx_send SHALL never be asserted in the same cycle nor for more than one consecutive cycle.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge from any state, aborting any transfer.
REQ-032 Reset values: src_rdnext=0, tx_send=0, tx_data=0, busy=0, grant_id=0, records_sent=0, tx_timeout=0, last_grant=N_SOURCES-1, timeout counter=0.
REQ-033 tx_timeout SHALL clear only by reset.

Verification
REQ-034 N=4, src_empty=4'b1110, enable=1 -> src_rdnext=4'b0001 at t+1, tx_send at t+3, tx_data[151:144]=0, [159:152]=8'h0A.
REQ-035 All four non-empty continuously, tx_done 5 cycles after each tx_send -> grant order 0,1,2,3,0; records_sent=5 after five dones.
REQ-036 Only source 2 non-empty after grant to 2 -> source 2 granted again (wrap search), grant_id=2.
REQ-037 TIMEOUT_CYCLES=16, tx_done never asserted -> tx_timeout=1 after 16 WAIT cycles, records_sent=0, FSM back to IDLE and next grant proceeds.
REQ-038 enable dropped the cycle after READ -> tx_send still pulses, record completes on tx_done, no further src_rdnext while enable=0.
REQ-039 reset asserted in WAIT -> next cycle busy=0, records_sent=0, tx_timeout=0; later tx_done ignored.
